// File: rtl/agc_pkg.sv
// Shared constants for the gain chain: gain indices, gain-to-scale table,
// ADC full-scale code and the amplitude meter state encoding.
package agc_pkg;

  localparam logic [1:0] GAIN_3X    = 2'd0;
  localparam logic [1:0] GAIN_6X5   = 2'd1;
  localparam logic [1:0] GAIN_13X5  = 2'd2;
  localparam logic [1:0] GAIN_29X25 = 2'd3;

  localparam int K_W         = 21;
  localparam int K_FRAC_BITS = 16;

  // K = round(2^16 * 2000 mV / 10 uV / (4096 * gain))
  localparam logic [K_W-1:0] K_3X    = 21'd1066667;
  localparam logic [K_W-1:0] K_6X5   = 21'd492308;
  localparam logic [K_W-1:0] K_13X5  = 21'd237037;
  localparam logic [K_W-1:0] K_29X25 = 21'd109402;

  localparam logic [11:0] ADC_FULL_SCALE = 12'd4095;
  localparam int          ADC_FS_MV      = 2000;
  localparam int          VPP_LSB_UV     = 10;

  typedef enum logic [2:0] {
    ST_WAIT_STABLE = 3'd0,
    ST_SETTLE      = 3'd1,
    ST_ACCUM       = 3'd2,
    ST_SCALE       = 3'd3,
    ST_OUTPUT      = 3'd4
  } meter_state_t;

  function automatic logic [K_W-1:0] gain_k(input logic [1:0] g);
    logic [K_W-1:0] k;
    case (g)
      GAIN_3X:    k = K_3X;
      GAIN_6X5:   k = K_6X5;
      GAIN_13X5:  k = K_13X5;
      GAIN_29X25: k = K_29X25;
      default:    k = K_3X;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/vpp_scaler.sv
// Two-stage pipeline converting a peak-to-peak ADC code into an
// input-referred amplitude: multiply by K[gain], then round and saturate.
module vpp_scaler
  import agc_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [11:0]      pp,
  input  logic [1:0]       gain,
  output logic [OUT_W-1:0] vpp,
  output logic             sat,
  output logic             out_valid
);

  localparam logic [17:0] VPP_MAX = 18'((64'd1 << OUT_W) - 64'd1);

  logic [32:0] prod_r;
  logic        v1_r;
  logic [17:0] shifted_s;
  logic        over_s;

  // Stage 1: full-width product of the code span and the gain scale factor.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_r <= 33'd0;
      v1_r   <= 1'b0;
    end else begin
      v1_r <= in_valid;
      if (in_valid) begin
        prod_r <= 33'(pp) * 33'(gain_k(gain));
      end
    end
  end

  // Round half-up on the 16 fractional bits, then check against the output range.
  always_comb begin
    shifted_s = 18'((34'(prod_r) + 34'd32768) >> K_FRAC_BITS);
    over_s    = (shifted_s > VPP_MAX);
  end

  // Stage 2: registered, saturated result.
  always_ff @(posedge clk) begin
    if (rst) begin
      vpp       <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= v1_r;
      if (v1_r) begin
        vpp <= over_s ? {OUT_W{1'b1}} : shifted_s[OUT_W-1:0];
        sat <= over_s;
      end
    end
  end

endmodule

// File: rtl/amplitude_meter.sv
// Measures peak-to-peak amplitude over a window of samples taken at a settled,
// constant gain and reports it input-referred on a valid/ready port.
module amplitude_meter
  import agc_pkg::*;
#(
  parameter int WINDOW         = 512,
  parameter int SETTLE_SAMPLES = 16,
  parameter int OUT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adc_valid,
  input  logic [11:0]      adc_data,
  input  logic [1:0]       gain_code,
  input  logic             gain_stable,
  output logic             vpp_valid,
  input  logic             vpp_ready,
  output logic [OUT_W-1:0] vpp_out,
  output logic [1:0]       vpp_gain,
  output logic             vpp_sat
);

  localparam int WCNT_W = $clog2(WINDOW);
  localparam int SCNT_W = $clog2(SETTLE_SAMPLES) + 1;

  meter_state_t state_r, state_s;

  logic [1:0]        g_r;
  logic [SCNT_W-1:0] settle_cnt_r;
  logic [WCNT_W-1:0] win_cnt_r;
  logic [11:0]       max_r, min_r;
  logic              clip_r;
  logic              scale_start_r;
  logic              vpp_valid_r;
  logic [OUT_W-1:0]  vpp_out_r;
  logic [1:0]        vpp_gain_r;
  logic              vpp_sat_r;

  logic              abort_s, settle_done_s, win_done_s, handshake_s;
  logic              latch_gain_s, settle_inc_s, accum_start_s, accum_s, capture_s;
  logic [11:0]       pp_s;
  logic [OUT_W-1:0]  sc_vpp_s;
  logic              sc_sat_s, sc_valid_s;

  // Condition decode shared by the next-state and output logic.
  always_comb begin
    abort_s       = ((state_r == ST_SETTLE) || (state_r == ST_ACCUM)) &&
                    (!gain_stable || (gain_code != g_r));
    settle_done_s = adc_valid && (settle_cnt_r == SCNT_W'(SETTLE_SAMPLES - 1));
    win_done_s    = adc_valid && (win_cnt_r == WCNT_W'(WINDOW - 1));
    handshake_s   = vpp_valid_r && vpp_ready;
    pp_s          = max_r - min_r;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_WAIT_STABLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; abort outranks both settle and window completion.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_WAIT_STABLE: begin
        if (gain_stable) state_s = ST_SETTLE;
        else             state_s = ST_WAIT_STABLE;
      end
      ST_SETTLE: begin
        if (abort_s)            state_s = ST_WAIT_STABLE;
        else if (settle_done_s) state_s = ST_ACCUM;
        else                    state_s = ST_SETTLE;
      end
      ST_ACCUM: begin
        if (abort_s)         state_s = ST_WAIT_STABLE;
        else if (win_done_s) state_s = ST_SCALE;
        else                 state_s = ST_ACCUM;
      end
      ST_SCALE: begin
        if (sc_valid_s) state_s = ST_OUTPUT;
        else            state_s = ST_SCALE;
      end
      ST_OUTPUT: begin
        if (handshake_s) state_s = gain_stable ? ST_SETTLE : ST_WAIT_STABLE;
        else             state_s = ST_OUTPUT;
      end
      default: state_s = ST_WAIT_STABLE;
    endcase
  end

  // Per-state datapath enables.
  always_comb begin
    latch_gain_s  = 1'b0;
    settle_inc_s  = 1'b0;
    accum_start_s = 1'b0;
    accum_s       = 1'b0;
    capture_s     = 1'b0;
    case (state_r)
      ST_WAIT_STABLE: latch_gain_s = gain_stable;
      ST_SETTLE: begin
        settle_inc_s  = adc_valid && !abort_s;
        accum_start_s = settle_done_s && !abort_s;
      end
      ST_ACCUM:  accum_s      = adc_valid && !abort_s;
      ST_SCALE:  capture_s    = sc_valid_s;
      ST_OUTPUT: latch_gain_s = handshake_s && gain_stable;
      default: begin
        latch_gain_s = 1'b0;
      end
    endcase
  end

  // Gain latch, settle/window counters and min/max tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      g_r           <= 2'd0;
      settle_cnt_r  <= '0;
      win_cnt_r     <= '0;
      max_r         <= 12'd0;
      min_r         <= ADC_FULL_SCALE;
      clip_r        <= 1'b0;
      scale_start_r <= 1'b0;
    end else begin
      scale_start_r <= accum_s && win_done_s;
      if (latch_gain_s) begin
        g_r          <= gain_code;
        settle_cnt_r <= '0;
      end else if (settle_inc_s) begin
        settle_cnt_r <= settle_cnt_r + SCNT_W'(1);
      end
      if (accum_start_s) begin
        max_r     <= 12'd0;
        min_r     <= ADC_FULL_SCALE;
        clip_r    <= 1'b0;
        win_cnt_r <= '0;
      end else if (accum_s) begin
        max_r     <= (adc_data > max_r) ? adc_data : max_r;
        min_r     <= (adc_data < min_r) ? adc_data : min_r;
        clip_r    <= clip_r | (adc_data == ADC_FULL_SCALE);
        win_cnt_r <= win_cnt_r + WCNT_W'(1);
      end
    end
  end

  vpp_scaler #(.OUT_W(OUT_W)) u_scaler (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (scale_start_r),
    .pp        (pp_s),
    .gain      (g_r),
    .vpp       (sc_vpp_s),
    .sat       (sc_sat_s),
    .out_valid (sc_valid_s)
  );

  // Result register: frozen from capture until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      vpp_valid_r <= 1'b0;
      vpp_out_r   <= '0;
      vpp_gain_r  <= 2'd0;
      vpp_sat_r   <= 1'b0;
    end else if (capture_s) begin
      vpp_valid_r <= 1'b1;
      vpp_out_r   <= sc_vpp_s;
      vpp_gain_r  <= g_r;
      vpp_sat_r   <= sc_sat_s | clip_r;
    end else if (handshake_s) begin
      vpp_valid_r <= 1'b0;
    end
  end

  assign vpp_valid = vpp_valid_r;
  assign vpp_out   = vpp_out_r;
  assign vpp_gain  = vpp_gain_r;
  assign vpp_sat   = vpp_sat_r;

endmodule

// File: tb/tb_amplitude_meter.sv
// Directed/randomized bench for amplitude_meter with a window-level reference model.
module tb_amplitude_meter;

  localparam int WINDOW = 512;
  localparam int SETTLE = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        adc_valid;
  logic [11:0] adc_data;
  logic [1:0]  gain_code;
  logic        gain_stable;
  logic        vpp_valid;
  logic        vpp_ready;
  logic [15:0] vpp_out;
  logic [1:0]  vpp_gain;
  logic        vpp_sat;

  int total = 0;
  int bad   = 0;
  int early = 0;
  int gap_cnt = 0;
  bit gaps = 1'b0;
  int wmax, wmin;
  bit wclip;

  always #5 clk = ~clk;

  amplitude_meter #(.WINDOW(WINDOW), .SETTLE_SAMPLES(SETTLE), .OUT_W(16)) dut (
    .clk(clk), .rst(rst), .adc_valid(adc_valid), .adc_data(adc_data),
    .gain_code(gain_code), .gain_stable(gain_stable), .vpp_valid(vpp_valid),
    .vpp_ready(vpp_ready), .vpp_out(vpp_out), .vpp_gain(vpp_gain), .vpp_sat(vpp_sat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: amplitude from the window span and the nominal analog gain.
  function automatic longint model_raw(input int pp, input int g);
    real gains[4] = '{3.0, 6.5, 13.5, 29.25};
    longint k;
    k = longint'($rtoi(65536.0 * 200000.0 / (4096.0 * gains[g]) + 0.5));
    return (longint'(pp) * k + 64'd32768) >> 16;
  endfunction

  function automatic int gen(input int kind, input int i, input int a, input int b);
    real ph;
    case (kind)
      0: begin
        ph = 2.0 * 3.14159265358979 * real'(i) / 64.0;
        return 2048 + $rtoi($floor(1024.0 * $sin(ph) + 0.5));
      end
      1: return ((i / 8) % 2 == 0) ? a : b;
      2: return a;
      3: return int'($urandom_range(b, a));
      4: return (i % 97 == 5) ? 4095 : int'($urandom_range(b, a));
      default: return 0;
    endcase
  endfunction

  task automatic send(input int d);
    if (gaps) begin
      gap_cnt++;
      if (gap_cnt % 20 == 0) begin
        tick();
        if (vpp_valid) early++;
      end
    end
    adc_valid = 1'b1;
    adc_data  = 12'(d);
    tick();
    adc_valid = 1'b0;
    if (vpp_valid) early++;
  endtask

  task automatic settle_junk();
    for (int i = 0; i < SETTLE; i++) send((i % 2 == 0) ? 0 : 4095);
  endtask

  task automatic window(input int kind, input int a, input int b, input int n);
    wmax = 0; wmin = 4095; wclip = 1'b0;
    for (int i = 0; i < n; i++) begin
      int d;
      d = gen(kind, i, a, b);
      if (d > wmax) wmax = d;
      if (d < wmin) wmin = d;
      if (d == 4095) wclip = 1'b1;
      send(d);
    end
  endtask

  task automatic regain(input int g);
    adc_valid = 1'b0;
    gain_stable = 1'b0;
    tick(); tick();
    gain_code = 2'(g);
    gain_stable = 1'b1;
    tick(); tick();
  endtask

  task automatic expect_result(input string tag, input int g, input bit chk_lat, input bit junk);
    int n;
    longint raw, ev;
    n = 0;
    while (!vpp_valid && n < 50) begin
      adc_valid = junk;
      adc_data  = ($urandom_range(1, 0) == 1) ? 12'd4095 : 12'd0;
      tick();
      adc_valid = 1'b0;
      n++;
    end
    check({tag, "_valid"}, longint'(vpp_valid), 1);
    if (chk_lat) check({tag, "_latency"}, n, 3);
    raw = model_raw(wmax - wmin, g);
    ev  = (raw > 65535) ? 65535 : raw;
    check({tag, "_vpp"}, longint'(vpp_out), ev);
    check({tag, "_gain"}, longint'(vpp_gain), g);
    check({tag, "_sat"}, longint'(vpp_sat), longint'((raw > 65535) || wclip));
    if (vpp_ready) begin
      tick();
      check({tag, "_drop"}, longint'(vpp_valid), 0);
    end
  endtask

  task automatic full_run(input string tag, input int g, input int kind, input int a, input int b);
    regain(g);
    early = 0;
    settle_junk();
    window(kind, a, b, WINDOW);
    check({tag, "_no_early"}, early, 0);
    expect_result(tag, g, 1'b1, 1'b1);
  endtask

  initial begin
    int held_out, held_gain, held_sat, hold_bad;
    rst = 1'b1; adc_valid = 1'b0; adc_data = 12'd0;
    gain_code = 2'd1; gain_stable = 1'b0; vpp_ready = 1'b1;
    tick(); tick(); tick();
    check("rst_valid", longint'(vpp_valid), 0);
    check("rst_vpp",   longint'(vpp_out), 0);
    check("rst_gain",  longint'(vpp_gain), 0);
    check("rst_sat",   longint'(vpp_sat), 0);
    rst = 1'b0;

    // Main function and boundary spans
    full_run("sine_g1", 1, 0, 0, 0);
    full_run("square_g3", 3, 1, 500, 1500);
    full_run("const_g2", 2, 2, 2048, 0);
    full_run("full_g0", 0, 1, 4095, 0);
    full_run("clip_g3", 3, 4, 100, 4000);
    for (int r = 0; r < 3; r++) begin
      int lo, hi;
      lo = int'($urandom_range(2000, 0));
      hi = int'($urandom_range(4094, 2001));
      full_run("rand", int'($urandom_range(3, 0)), 3, lo, hi);
    end

    // Gain change mid-window aborts; next result after fresh settle + window at gain 2
    regain(1);
    early = 0;
    settle_junk();
    window(3, 0, 4095, 300);
    gain_code = 2'd2;
    send(4095);
    adc_valid = 1'b0;
    tick(); tick();
    settle_junk();
    window(3, 1000, 1400, WINDOW);
    check("gchg_no_early", early, 0);
    expect_result("gchg", 2, 1'b1, 1'b0);

    // gain_stable drop mid-window aborts likewise
    regain(1);
    early = 0;
    settle_junk();
    window(3, 0, 4095, 200);
    gain_stable = 1'b0;
    for (int i = 0; i < 5; i++) send(4095);
    gain_stable = 1'b1;
    tick(); tick();
    settle_junk();
    window(1, 1200, 2200, WINDOW);
    check("gdrop_no_early", early, 0);
    expect_result("gdrop", 1, 1'b1, 1'b0);

    // Backpressure: result held while samples keep streaming
    regain(2);
    vpp_ready = 1'b0;
    settle_junk();
    window(3, 300, 3800, WINDOW);
    expect_result("bp", 2, 1'b1, 1'b1);
    held_out = vpp_out; held_gain = vpp_gain; held_sat = vpp_sat;
    hold_bad = 0;
    for (int i = 0; i < 2000; i++) begin
      adc_valid = 1'b1;
      adc_data  = 12'($urandom_range(4095, 0));
      tick();
      if (vpp_valid !== 1'b1 || int'(vpp_out) != held_out ||
          int'(vpp_gain) != held_gain || int'(vpp_sat) != held_sat) hold_bad++;
    end
    adc_valid = 1'b0;
    check("bp_hold", hold_bad, 0);
    vpp_ready = 1'b1;
    tick();
    check("bp_drop", longint'(vpp_valid), 0);
    early = 0;
    settle_junk();
    window(1, 700, 2900, WINDOW);
    check("bp_next_no_early", early, 0);
    expect_result("bp_next", 2, 1'b1, 1'b0);

    // Reset while a result is pending
    regain(0);
    vpp_ready = 1'b0;
    settle_junk();
    window(3, 100, 3000, WINDOW);
    expect_result("prerst", 0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", longint'(vpp_valid), 0);
    check("midrst_vpp",   longint'(vpp_out), 0);
    check("midrst_gain",  longint'(vpp_gain), 0);
    check("midrst_sat",   longint'(vpp_sat), 0);
    vpp_ready = 1'b1;

    // Sparse sample strobes give the same answer as dense ones
    gaps = 1'b1;
    gap_cnt = 0;
    regain(1);
    early = 0;
    settle_junk();
    window(0, 0, 0, WINDOW);
    check("gaps_no_early", early, 0);
    expect_result("gaps", 1, 1'b1, 1'b0);
    gaps = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
